// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'd0,
    SIZE_HALF    = 2'd1,
    SIZE_WORD    = 2'd2,
    SIZE_ILLEGAL = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  function automatic logic [3:0] size_to_bytes(input mem_size_e size);
    case (size)
      SIZE_BYTE: size_to_bytes = 4'd1;
      SIZE_HALF: size_to_bytes = 4'd2;
      SIZE_WORD: size_to_bytes = 4'd4;
      default:   size_to_bytes = 4'd0;
    endcase
  endfunction

  // Only the two low address bits matter for natural alignment up to a word.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lo);
    case (size)
      SIZE_HALF: is_misaligned = addr_lo[0];
      SIZE_WORD: is_misaligned = (addr_lo != 2'b00);
      default:   is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sign/zero extension of LSB-aligned load data
module load_extend
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] raw_data,
  input  mem_size_e             size,
  input  logic                  is_signed,
  output logic [DATA_WIDTH-1:0] ext_data
);

  always_comb begin
    ext_data = raw_data;
    case (size)
      SIZE_BYTE: ext_data = {{(DATA_WIDTH-8){is_signed & raw_data[7]}}, raw_data[7:0]};
      SIZE_HALF: ext_data = {{(DATA_WIDTH-16){is_signed & raw_data[15]}}, raw_data[15:0]};
      default:   ext_data = raw_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with alignment check
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_is_store,
  input  logic [1:0]                          req_size,
  input  logic                                req_signed,
  input  logic [ADDR_WIDTH-1:0]               req_addr,
  input  logic [DATA_WIDTH-1:0]               req_wdata,
  input  logic [TAG_WIDTH-1:0]                req_tag,
  output logic                                resp_valid,
  input  logic                                resp_ready,
  output logic [DATA_WIDTH-1:0]               resp_data,
  output logic [TAG_WIDTH-1:0]                resp_tag,
  output logic                                resp_fault,
  output logic [ADDR_WIDTH-1:0]               fetch_addr,
  input  logic [DATA_WIDTH-1:0]               fetched_data,
  input  logic                                fetch_done,
  output logic [ADDR_WIDTH-1:0]               write_addr,
  output logic [DATA_WIDTH-1:0]               write_data,
  output logic [$clog2(DATA_WIDTH/8):0]       bytes_to_write,
  output logic                                write_data_valid,
  input  logic                                write_done
);

  localparam int BTW_W = $clog2(DATA_WIDTH/8) + 1;

  lsu_state_e            state_q, state_d;
  mem_size_e             size_q, size_d;
  logic                  signed_q, signed_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  fault_q, fault_d;

  logic [DATA_WIDTH-1:0] ext_data;
  mem_size_e             in_size;
  logic                  in_fault;

  assign in_size  = mem_size_e'(req_size);
  assign in_fault = (in_size == SIZE_ILLEGAL) || is_misaligned(in_size, req_addr[1:0]);

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .raw_data  (fetched_data),
    .size      (size_q),
    .is_signed (signed_q),
    .ext_data  (ext_data)
  );

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    signed_d     = signed_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    tag_d        = tag_q;
    fetch_addr_d = fetch_addr_q;
    resp_data_d  = resp_data_q;
    fault_d      = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          size_d      = in_size;
          signed_d    = req_signed;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          tag_d       = req_tag;
          resp_data_d = '0;
          fault_d     = in_fault;
          if (in_fault) begin
            state_d = ST_RESP;
          end else if (req_is_store) begin
            state_d = ST_STORE;
          end else begin
            // fetch_addr only moves when a real load is issued, so it holds otherwise.
            fetch_addr_d = req_addr;
            state_d      = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (fetch_done) begin
          resp_data_d = ext_data;
          state_d     = ST_RESP;
        end
      end
      ST_STORE: begin
        if (write_done) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      size_q       <= SIZE_BYTE;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      tag_q        <= '0;
      fetch_addr_q <= '0;
      resp_data_q  <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      tag_q        <= tag_d;
      fetch_addr_q <= fetch_addr_d;
      resp_data_q  <= resp_data_d;
      fault_q      <= fault_d;
    end
  end

  assign req_ready        = (state_q == ST_IDLE);
  assign resp_valid       = (state_q == ST_RESP);
  assign resp_data        = resp_data_q;
  assign resp_tag         = tag_q;
  assign resp_fault       = fault_q;
  assign fetch_addr       = fetch_addr_q;
  assign write_data_valid = (state_q == ST_STORE);
  assign write_addr       = write_data_valid ? addr_q : '0;
  assign write_data       = write_data_valid ? wdata_q : '0;
  assign bytes_to_write   = write_data_valid ? BTW_W'(size_to_bytes(size_q)) : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_tag;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic [31:0] fetch_addr, fetched_data, write_addr, write_data;
  logic        fetch_done, write_data_valid, write_done;
  logic [2:0]  bytes_to_write;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [0:1023];

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_fault(resp_fault),
    .fetch_addr(fetch_addr), .fetched_data(fetched_data), .fetch_done(fetch_done),
    .write_addr(write_addr), .write_data(write_data), .bytes_to_write(bytes_to_write),
    .write_data_valid(write_data_valid), .write_done(write_done)
  );

  // Little-endian byte memory returning LSB-aligned data from the byte address.
  always_comb begin
    fetched_data = {mem[(fetch_addr[9:0] + 10'd3)], mem[(fetch_addr[9:0] + 10'd2)],
                    mem[(fetch_addr[9:0] + 10'd1)], mem[fetch_addr[9:0]]};
  end

  always @(posedge clk) begin
    if (write_data_valid && write_done) begin
      for (int k = 0; k < 4; k++)
        if (k < int'(bytes_to_write)) mem[write_addr[9:0] + 10'(k)] <= write_data[k*8 +: 8];
    end
  end

  typedef struct {
    logic        is_store;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  tag;
    logic        exp_fault;
    logic [31:0] exp_data;
    logic [2:0]  exp_btw;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v);
    int   waited;
    logic saw_wv;
    logic [2:0] btw_seen;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_is_store = v.is_store; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata; req_tag = v.tag;
    @(posedge clk); #1;
    req_valid = 1'b0;
    waited = 0; saw_wv = 1'b0; btw_seen = '0;
    @(negedge clk);
    while (!resp_valid && waited < 20) begin
      if (write_data_valid) begin saw_wv = 1'b1; btw_seen = bytes_to_write; end
      waited++;
      @(negedge clk);
    end
    if (!resp_valid) begin
      vectors++; miscompares++;
      $display("FAIL resp_timeout: got no resp_valid expected resp_valid within 20 cycles");
      return;
    end
    chk("latency", waited, v.exp_fault ? 32'd0 : 32'd1);
    chk("resp_data", resp_data, v.exp_data);
    chk("resp_tag", {27'b0, resp_tag}, {27'b0, v.tag});
    chk("resp_fault", {31'b0, resp_fault}, {31'b0, v.exp_fault});
    if (v.is_store) begin
      chk("store_wv_seen", {31'b0, saw_wv}, {31'b0, ~v.exp_fault});
      if (!v.exp_fault) chk("bytes_to_write", {29'b0, btw_seen}, {29'b0, v.exp_btw});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  function automatic vec_t mk(input logic st, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] wd, input logic [4:0] tg,
                              input logic f, input logic [31:0] d, input logic [2:0] b);
    vec_t r;
    r.is_store = st; r.size = sz; r.sgn = sg; r.addr = a; r.wdata = wd; r.tag = tg;
    r.exp_fault = f; r.exp_data = d; r.exp_btw = b;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; req_tag = '0; resp_ready = 1'b0;
    fetch_done = 1'b1; write_done = 1'b1;

    vecs[0]  = mk(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 5'd1,  0, 32'h0,        3'd4);
    vecs[1]  = mk(0, 2'd2, 0, 32'h100, 32'h0,        5'd2,  0, 32'hDEADBEEF, 3'd0);
    vecs[2]  = mk(0, 2'd0, 1, 32'h103, 32'h0,        5'd3,  0, 32'hFFFFFFDE, 3'd0);
    vecs[3]  = mk(0, 2'd0, 0, 32'h103, 32'h0,        5'd4,  0, 32'h000000DE, 3'd0);
    vecs[4]  = mk(0, 2'd1, 1, 32'h100, 32'h0,        5'd5,  0, 32'hFFFFBEEF, 3'd0);
    vecs[5]  = mk(0, 2'd1, 1, 32'h101, 32'h0,        5'd7,  1, 32'h0,        3'd0);
    vecs[6]  = mk(1, 2'd2, 0, 32'h102, 32'h12345678, 5'd8,  1, 32'h0,        3'd0);
    vecs[7]  = mk(0, 2'd2, 0, 32'h100, 32'h0,        5'd10, 0, 32'hDEADBEEF, 3'd0);
    vecs[8]  = mk(1, 2'd3, 0, 32'h200, 32'hFFFFFFFF, 5'd11, 1, 32'h0,        3'd0);
    vecs[9]  = mk(0, 2'd1, 0, 32'h102, 32'h0,        5'd12, 0, 32'h0000DEAD, 3'd0);
    vecs[10] = mk(1, 2'd1, 0, 32'h202, 32'h1111CAFE, 5'd13, 0, 32'h0,        3'd2);
    vecs[11] = mk(1, 2'd0, 0, 32'h201, 32'h222222AB, 5'd14, 0, 32'h0,        3'd1);
    vecs[12] = mk(0, 2'd2, 0, 32'h200, 32'h0,        5'd15, 0, 32'hCAFEAB00, 3'd0);
    vecs[13] = mk(0, 2'd0, 1, 32'h201, 32'h0,        5'd16, 0, 32'hFFFFFFAB, 3'd0);
    vecs[14] = mk(0, 2'd2, 1, 32'h200, 32'h0,        5'd31, 0, 32'hCAFEAB00, 3'd0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_wdv", {31'b0, write_data_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_tag", {27'b0, resp_tag}, 32'd0);
    chk("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
    chk("rst_fetch_addr", fetch_addr, 32'd0);
    chk("rst_write_addr", write_addr, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_btw", {29'b0, bytes_to_write}, 32'd0);

    for (int i = 0; i < 15; i++) do_req(vecs[i]);

    // Stalled store with back-pressured response and a competing request.
    write_done = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h300; req_wdata = 32'h55667788; req_tag = 5'd9;
    @(posedge clk); #1;
    req_is_store = 1'b0; req_addr = 32'h100; req_tag = 5'd20;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_wdv", {31'b0, write_data_valid}, 32'd1);
      chk("stall_waddr", write_addr, 32'h300);
      chk("stall_wdata", write_data, 32'h55667788);
      chk("stall_btw", {29'b0, bytes_to_write}, 32'd4);
      chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
      chk("stall_fetch_addr", fetch_addr, 32'h200);
    end
    write_done = 1'b1;
    @(posedge clk); #1;
    write_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 3) req_valid = 1'b0;
      chk("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_resp_tag", {27'b0, resp_tag}, 32'd9);
      chk("hold_resp_data", resp_data, 32'd0);
      chk("hold_resp_fault", {31'b0, resp_fault}, 32'd0);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
      chk("hold_no_write", {31'b0, write_data_valid}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("after_resp_idle", {31'b0, req_ready}, 32'd1);
    chk("after_resp_valid", {31'b0, resp_valid}, 32'd0);
    write_done = 1'b1;
    do_req(mk(0, 2'd2, 0, 32'h300, 32'h0, 5'd21, 0, 32'h55667788, 3'd0));

    // Reset in the middle of a stalled store abandons it.
    write_done = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'd2;
    req_addr = 32'h100; req_wdata = 32'h99999999; req_tag = 5'd22;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_wdv", {31'b0, write_data_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    write_done = 1'b1;
    @(negedge clk);
    chk("midrst_wdv", {31'b0, write_data_valid}, 32'd0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("midrst_btw", {29'b0, bytes_to_write}, 32'd0);
    chk("midrst_tag", {27'b0, resp_tag}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_no_resp", {31'b0, resp_valid}, 32'd0);
    end
    do_req(mk(0, 2'd2, 0, 32'h100, 32'h0, 5'd23, 0, 32'hDEADBEEF, 3'd0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
